// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and helpers for the TPU feed path.
//   skew_state_e : tile_skewer control states.
//   step_w()     : width of the wavefront step counter for a given tile size.
package tpu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2
   } skew_state_e;

   // A SIZE x SIZE wavefront spans 2*SIZE-1 steps (0..2*SIZE-2).
   function automatic int step_w(input int size);
      return $clog2(2 * size - 1);
   endfunction

endpackage

// File: rtl/tile_skewer.sv
// tile_skewer: pops SIZE x SIZE tiles from the tile FIFO and streams them into
// the systolic array row inputs as a diagonal wavefront (row r lags row 0 by
// r cycles). Optional per-tile transpose streams columns instead of rows.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   pop          FIFO pop request (combinational)
//   pop_rdy      FIFO non-empty
//   din          FIFO data, din[r][c]; valid the cycle after a pop handshake
//   transpose    sampled with pop; 1 = stream tile columns
//   array_rdy    array accepts a beat this cycle
//   row_data     per-row element, row_data[r]
//   row_valid    per-row element valid
//   busy         not IDLE
//   tile_done    pulse on the final accepted beat of a tile
module tile_skewer
   import tpu_pkg::*;
#(
   parameter int BITS = 8,
   parameter int SIZE = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   output logic                                 pop,
   input  logic                                 pop_rdy,
   input  logic [SIZE-1:0][SIZE-1:0][BITS-1:0]  din,
   input  logic                                 transpose,
   input  logic                                 array_rdy,
   output logic [SIZE-1:0][BITS-1:0]            row_data,
   output logic [SIZE-1:0]                      row_valid,
   output logic                                 busy,
   output logic                                 tile_done
);

   localparam int SW = step_w(SIZE);
   localparam int IW = $clog2(SIZE);
   localparam logic [SW-1:0] LAST = SW'(2 * SIZE - 2);

   skew_state_e                         state;
   logic [SW-1:0]                       step;
   logic [SIZE-1:0][SIZE-1:0][BITS-1:0] tile;
   logic                                xpose;
   logic                                last;

   // Next tile is only popped on the accepted last beat, so a stall on the
   // final step can never overwrite an unfinished tile.
   always_comb begin
      last      = (state == STREAM) && (step == LAST);
      pop       = pop_rdy && ((state == IDLE) || (last && array_rdy));
      tile_done = last && array_rdy;
      busy      = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         step  <= '0;
         tile  <= '0;
         xpose <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  state <= LOAD;
                  xpose <= transpose;
               end
            end
            // FIFO read data lands here, one cycle after the pop handshake.
            LOAD: begin
               tile  <= din;
               step  <= '0;
               state <= STREAM;
            end
            STREAM: begin
               if (array_rdy) begin
                  if (step != LAST) begin
                     step <= step + 1'b1;
                  end else begin
                     step <= '0;
                     if (pop) begin
                        state <= LOAD;
                        xpose <= transpose;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Diagonal select: row r presents element k = step - r while 0 <= k < SIZE.
   for (genvar r = 0; r < SIZE; r++) begin : g_row
      logic [SW-1:0] k;
      logic          in_rng;
      assign k      = step - SW'(r);
      assign in_rng = (state == STREAM) && (step >= SW'(r)) && (k < SW'(SIZE));
      assign row_valid[r] = in_rng;
      assign row_data[r]  = !in_rng ? '0 :
                            xpose   ? tile[k[IW-1:0]][r] : tile[r][k[IW-1:0]];
   end

endmodule

// File: tb/tb_tile_skewer.sv
// tb_tile_skewer: directed cycle-by-cycle checks of tile_skewer (SIZE=2, BITS=8).
// Each step drives inputs, then compares {pop, row_valid, row_data[1],
// row_data[0], tile_done, busy} against a hand-computed vector.
module tb_tile_skewer;

   localparam int BITS = 8;
   localparam int SIZE = 2;

   logic                                clk;
   logic                                rst_n;
   logic                                pop;
   logic                                pop_rdy;
   logic [SIZE-1:0][SIZE-1:0][BITS-1:0] din;
   logic                                transpose;
   logic                                array_rdy;
   logic [SIZE-1:0][BITS-1:0]           row_data;
   logic [SIZE-1:0]                     row_valid;
   logic                                busy;
   logic                                tile_done;

   int n_cmp  = 0;
   int n_fail = 0;

   tile_skewer #(.BITS(BITS), .SIZE(SIZE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pop       (pop),
      .pop_rdy   (pop_rdy),
      .din       (din),
      .transpose (transpose),
      .array_rdy (array_rdy),
      .row_data  (row_data),
      .row_valid (row_valid),
      .busy      (busy),
      .tile_done (tile_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tiles as {t[1][1], t[1][0], t[0][1], t[0][0]}.
   localparam logic [31:0] TILE_A = {8'd4, 8'd3, 8'd2, 8'd1};
   localparam logic [31:0] TILE_B = {8'd8, 8'd7, 8'd6, 8'd5};
   localparam logic [31:0] TILE_C = {8'd12, 8'd11, 8'd10, 8'd9};

   function automatic logic [20:0] ev(input logic p, input logic [1:0] v,
                                      input logic [7:0] r1, input logic [7:0] r0,
                                      input logic d, input logic b);
      return {p, v, r1, r0, d, b};
   endfunction

   // Drive one cycle's inputs (just after negedge), compare, advance a cycle.
   task automatic t(input string tag, input logic prdy, input logic xp,
                    input logic ardy, input logic rstn, input logic [20:0] exp);
      logic [20:0] obs;
      rst_n     = rstn;
      pop_rdy   = prdy;
      transpose = xp;
      array_rdy = ardy;
      #1;
      obs = {pop, row_valid, row_data[1], row_data[0], tile_done, busy};
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; pop_rdy = 1'b0; transpose = 1'b0; array_rdy = 1'b1;
      din = TILE_A;
      @(negedge clk);
      t("reset",   0, 0, 1, 0, ev(0, 2'b00, 0, 0, 0, 0));
      t("idle",    0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 0));

      // Single tile, row-major.
      t("n_pop",   1, 0, 1, 1, ev(1, 2'b00, 0, 0, 0, 0));
      t("n_load",  0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 1));
      t("n_s0",    0, 0, 1, 1, ev(0, 2'b01, 0, 1, 0, 1));
      t("n_s1",    0, 0, 1, 1, ev(0, 2'b11, 3, 2, 0, 1));
      t("n_s2",    0, 0, 1, 1, ev(0, 2'b10, 4, 0, 1, 1));
      t("n_idle",  0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 0));

      // Transposed tile; transpose toggles mid-stream without effect.
      t("x_pop",   1, 1, 1, 1, ev(1, 2'b00, 0, 0, 0, 0));
      t("x_load",  0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 1));
      t("x_s0",    0, 0, 1, 1, ev(0, 2'b01, 0, 1, 0, 1));
      t("x_s1",    0, 1, 1, 1, ev(0, 2'b11, 2, 3, 0, 1));
      t("x_s2",    0, 0, 1, 1, ev(0, 2'b10, 4, 0, 1, 1));
      t("x_idle",  0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 0));

      // Back-to-back: second pop on first tile's last beat, one LOAD bubble.
      t("b_pop",   1, 0, 1, 1, ev(1, 2'b00, 0, 0, 0, 0));
      t("b_load",  1, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 1));
      t("b_s0",    1, 0, 1, 1, ev(0, 2'b01, 0, 1, 0, 1));
      t("b_s1",    1, 0, 1, 1, ev(0, 2'b11, 3, 2, 0, 1));
      t("b_s2",    1, 0, 1, 1, ev(1, 2'b10, 4, 0, 1, 1));
      din = TILE_B;
      t("b_load2", 1, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 1));
      t("b2_s0",   1, 0, 1, 1, ev(0, 2'b01, 0, 5, 0, 1));
      t("b2_s1",   1, 0, 1, 1, ev(0, 2'b11, 7, 6, 0, 1));
      t("b2_s2",   0, 0, 1, 1, ev(0, 2'b10, 8, 0, 1, 1));
      t("b_idle",  0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 0));

      // Two-cycle stall at step 1.
      din = TILE_A;
      t("s_pop",   1, 0, 1, 1, ev(1, 2'b00, 0, 0, 0, 0));
      t("s_load",  0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 1));
      t("s_s0",    0, 0, 1, 1, ev(0, 2'b01, 0, 1, 0, 1));
      t("s_st1",   1, 0, 0, 1, ev(0, 2'b11, 3, 2, 0, 1));
      t("s_st2",   1, 0, 0, 1, ev(0, 2'b11, 3, 2, 0, 1));
      t("s_s1",    0, 0, 1, 1, ev(0, 2'b11, 3, 2, 0, 1));
      t("s_s2",    0, 0, 1, 1, ev(0, 2'b10, 4, 0, 1, 1));
      t("s_idle",  0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 0));

      // FIFO empty: stays idle; pop follows pop_rdy in the same cycle.
      t("e_0",     0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 0));
      t("e_1",     0, 0, 0, 1, ev(0, 2'b00, 0, 0, 0, 0));
      t("e_pop",   1, 0, 1, 1, ev(1, 2'b00, 0, 0, 0, 0));
      t("e_load",  0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 1));
      t("e_s0",    0, 0, 1, 1, ev(0, 2'b01, 0, 1, 0, 1));
      t("e_s1",    0, 0, 1, 1, ev(0, 2'b11, 3, 2, 0, 1));
      // Stall on last step with FIFO ready: pop withheld.
      t("l_stall", 1, 0, 0, 1, ev(0, 2'b10, 4, 0, 0, 1));
      t("l_s2",    0, 0, 1, 1, ev(0, 2'b10, 4, 0, 1, 1));
      t("l_idle",  0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 0));

      // Reset at step 1 discards tile C.
      din = TILE_C;
      t("r_pop",   1, 0, 1, 1, ev(1, 2'b00, 0, 0, 0, 0));
      t("r_load",  0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 1));
      t("r_s0",    0, 0, 1, 1, ev(0, 2'b01, 0, 9, 0, 1));
      t("r_s1",    0, 0, 1, 0, ev(0, 2'b11, 11, 10, 0, 1));
      din = TILE_A;
      t("r_idle",  0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 0));
      t("r2_pop",  1, 0, 1, 1, ev(1, 2'b00, 0, 0, 0, 0));
      t("r2_load", 0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 1));
      t("r2_s0",   0, 0, 1, 1, ev(0, 2'b01, 0, 1, 0, 1));
      t("r2_s1",   0, 0, 1, 1, ev(0, 2'b11, 3, 2, 0, 1));
      t("r2_s2",   0, 0, 1, 1, ev(0, 2'b10, 4, 0, 1, 1));
      t("r2_idle", 0, 0, 1, 1, ev(0, 2'b00, 0, 0, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
